// File: rtl/pyc_mem_arb_pkg.sv
// pyc_mem_arb_pkg
//   Shared types and helpers for the two-port memory arbiter.
//   - port_idx_t : one-bit port index (also the round-robin pointer type)
//   - grant_e    : which port, if any, owns the memory this cycle
//   - NUM_PORTS, STAT_WIDTH : arbiter geometry and statistics counter width
//   - arbitrate() : round-robin pick between the two eligible flags
//   - sat_inc()   : saturating increment for the statistics counters
package pyc_mem_arb_pkg;

  localparam int NUM_PORTS  = 2;
  localparam int STAT_WIDTH = 32;

  typedef logic [0:0] port_idx_t;

  localparam port_idx_t PORT0 = 1'b0;
  localparam port_idx_t PORT1 = 1'b1;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_PORT0 = 2'd1,
    GNT_PORT1 = 2'd2
  } grant_e;

  // A lone eligible port always wins; on a tie the pointer names the winner.
  function automatic grant_e arbitrate(input logic [NUM_PORTS-1:0] elig,
                                       input port_idx_t prio);
    grant_e g;
    g = GNT_NONE;
    if (elig[0] && elig[1]) begin
      g = (prio == PORT0) ? GNT_PORT0 : GNT_PORT1;
    end else if (elig[0]) begin
      g = GNT_PORT0;
    end else if (elig[1]) begin
      g = GNT_PORT1;
    end
    return g;
  endfunction

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pyc_mem_arb_rsp_slot.sv
// pyc_mem_arb_rsp_slot
//   One-entry response buffer for a single arbiter port.
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset
//     load        : port was granted this cycle; capture load_data
//     load_data   : read data (or zero for a write) to hold
//     free        : slot can accept a load this cycle (empty or draining)
//     rsp_valid   : response held
//     rsp_ready   : consumer takes the response this cycle
//     rsp_rdata   : held response data
module pyc_mem_arb_rsp_slot #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  free,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata
);

  // A draining slot counts as free so one access per cycle can be sustained.
  assign free = ~rsp_valid | rsp_ready;

  // A load wins over a drain: the new response replaces the one leaving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= load_data;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pyc_mem_arb.sv
// pyc_mem_arb
//   Two-requester round-robin arbiter in front of a byte-enabled memory with
//   combinational reads. One access is granted per cycle; each port owns a
//   one-entry response slot that is loaded at the grant edge.
//   Ports:
//     clk, rst                 : clock, asynchronous active-high reset
//     reqN_valid/ready         : request handshake (ready = granted this cycle)
//     reqN_write/addr/wdata/wstrb : request payload
//     rspN_valid/ready/rdata   : response handshake and data (0 for writes)
//     mem_raddr / mem_rdata    : memory read port (combinational data)
//     mem_wvalid/waddr/wdata/wstrb : memory write port
//     stat_grant0/1            : saturating per-port grant counters
//   Build option: define PYC_MEM_ARB_STATS_EN to add the stat_grant0/1
//   outputs and counters; without it they are absent.
module pyc_mem_arb
  import pyc_mem_arb_pkg::*;
#(
  parameter  int ADDR_WIDTH = 64,
  parameter  int DATA_WIDTH = 64,
  localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [STRB_WIDTH-1:0] req0_wstrb,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [STRB_WIDTH-1:0] req1_wstrb,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,

`ifdef PYC_MEM_ARB_STATS_EN
  output logic [STAT_WIDTH-1:0] stat_grant0,
  output logic [STAT_WIDTH-1:0] stat_grant1,
`endif

  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wvalid,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_wstrb
);

  logic [NUM_PORTS-1:0] slot_free;
  logic [NUM_PORTS-1:0] elig;
  port_idx_t            prio;
  grant_e               grant;

  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_wstrb;
  logic                  granted;
  logic [DATA_WIDTH-1:0] load_data;

  // Reset gates eligibility so no grant or memory write escapes while it is held.
  assign elig[0] = req0_valid & slot_free[0] & ~rst;
  assign elig[1] = req1_valid & slot_free[1] & ~rst;

  always_comb begin
    grant = arbitrate(elig, prio);
  end

  assign req0_ready = (grant == GNT_PORT0);
  assign req1_ready = (grant == GNT_PORT1);
  assign granted    = (grant != GNT_NONE);

  // The pointer only moves on contested cycles, handing the next tie to the loser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= PORT0;
    end else if (elig[0] && elig[1]) begin
      prio <= (grant == GNT_PORT0) ? PORT1 : PORT0;
    end
  end

  // Route the winner's payload; idle cycles present all-zero memory signals.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    case (grant)
      GNT_PORT0: begin
        sel_write = req0_write;
        sel_addr  = req0_addr;
        sel_wdata = req0_wdata;
        sel_wstrb = req0_wstrb;
      end
      GNT_PORT1: begin
        sel_write = req1_write;
        sel_addr  = req1_addr;
        sel_wdata = req1_wdata;
        sel_wstrb = req1_wstrb;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_raddr  = '0;
    mem_wvalid = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    if (granted) begin
      if (sel_write) begin
        mem_wvalid = 1'b1;
        mem_waddr  = sel_addr;
        mem_wdata  = sel_wdata;
        mem_wstrb  = sel_wstrb;
      end else begin
        mem_raddr = sel_addr;
      end
    end
  end

  // Writes return zero; reads capture the combinational memory data.
  assign load_data = sel_write ? '0 : mem_rdata;

  pyc_mem_arb_rsp_slot #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .load      (req0_ready),
    .load_data (load_data),
    .free      (slot_free[0]),
    .rsp_valid (rsp0_valid),
    .rsp_ready (rsp0_ready),
    .rsp_rdata (rsp0_rdata)
  );

  pyc_mem_arb_rsp_slot #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (req1_ready),
    .load_data (load_data),
    .free      (slot_free[1]),
    .rsp_valid (rsp1_valid),
    .rsp_ready (rsp1_ready),
    .rsp_rdata (rsp1_rdata)
  );

`ifdef PYC_MEM_ARB_STATS_EN
  // Per-port grant counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
    end else begin
      if (req0_ready) stat_grant0 <= sat_inc(stat_grant0);
      if (req1_ready) stat_grant1 <= sat_inc(stat_grant1);
    end
  end
`endif

endmodule

// File: tb/tb_pyc_mem_arb.sv
// tb_pyc_mem_arb
//   Directed bench for pyc_mem_arb with a 256-byte memory model. Expected
//   responses are queued per port as requests are issued and a monitor pops
//   them on every response handshake.
module tb_pyc_mem_arb;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = 8;

  localparam logic [63:0] PAT_A = 64'h1122334455667788;
  localparam logic [63:0] PAT_B = 64'h00000000000000AB;

  logic          clk = 1'b0;
  logic          rst;

  logic          req0_valid, req0_ready, req0_write;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic [SW-1:0] req0_wstrb;
  logic          rsp0_valid, rsp0_ready;
  logic [DW-1:0] rsp0_rdata;

  logic          req1_valid, req1_ready, req1_write;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic [SW-1:0] req1_wstrb;
  logic          rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp1_rdata;

  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          mem_wvalid;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;

`ifdef PYC_MEM_ARB_STATS_EN
  logic [31:0]   stat_grant0, stat_grant1;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] exp0[$];
  logic [63:0] exp1[$];

  logic [7:0] mem [0:255] = '{default: 8'h00};

  always #5 clk = ~clk;

  pyc_mem_arb #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_wstrb (req0_wstrb),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_rdata (rsp0_rdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_wstrb (req1_wstrb),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_rdata (rsp1_rdata),
`ifdef PYC_MEM_ARB_STATS_EN
    .stat_grant0 (stat_grant0),
    .stat_grant1 (stat_grant1),
`endif
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_wvalid (mem_wvalid),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb)
  );

  // Byte memory: combinational little-endian read, byte-enabled clocked write.
  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      mem_rdata[i*8 +: 8] = mem[8'(mem_raddr[7:0] + 8'(i))];
    end
  end

  always @(posedge clk) begin
    if (mem_wvalid) begin
      for (int i = 0; i < 8; i++) begin
        if (mem_wstrb[i]) mem[8'(mem_waddr[7:0] + 8'(i))] <= mem_wdata[i*8 +: 8];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic w0, input logic [63:0] a0,
                               input logic [63:0] d0, input logic [7:0] s0,
                               input logic v1, input logic w1, input logic [63:0] a1,
                               input logic [63:0] d1, input logic [7:0] s1);
    req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0; req0_wstrb = s0;
    req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1; req1_wstrb = s1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every response handshake pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp0_valid && rsp0_ready) begin
        if (exp0.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL rsp0_unexpected: actual=%h expected=none", rsp0_rdata);
        end else begin
          checkOutput("rsp0_rdata", rsp0_rdata, exp0.pop_front());
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (exp1.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL rsp1_unexpected: actual=%h expected=none", rsp1_rdata);
        end else begin
          checkOutput("rsp1_rdata", rsp1_rdata, exp1.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    #2;
    checkOutput("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
    checkOutput("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
    checkOutput("rst_rsp0_rdata", rsp0_rdata, 64'd0);
    checkOutput("rst_rsp1_rdata", rsp1_rdata, 64'd0);
    checkOutput("rst_mem_wvalid", 64'(mem_wvalid), 64'd0);
    next_cycle();
    rst = 1'b0;

    // Port 0 full-word write then read back
    applyStimulus(1, 1, 64'h10, PAT_A, 8'hFF, 0, 0, 0, 0, 0);
    exp0.push_back(64'd0);
    @(negedge clk);
    checkOutput("wr0_req0_ready", 64'(req0_ready), 64'd1);
    checkOutput("wr0_req1_ready", 64'(req1_ready), 64'd0);
    checkOutput("wr0_mem_wvalid", 64'(mem_wvalid), 64'd1);
    checkOutput("wr0_mem_waddr", mem_waddr, 64'h10);
    checkOutput("wr0_mem_wdata", mem_wdata, PAT_A);
    checkOutput("wr0_mem_wstrb", 64'(mem_wstrb), 64'hFF);
    next_cycle();
    applyStimulus(1, 0, 64'h10, 0, 0, 0, 0, 0, 0, 0);
    exp0.push_back(PAT_A);
    @(negedge clk);
    checkOutput("rd0_req0_ready", 64'(req0_ready), 64'd1);
    checkOutput("rd0_mem_raddr", mem_raddr, 64'h10);
    checkOutput("rd0_mem_wvalid", 64'(mem_wvalid), 64'd0);
    next_cycle();

    // Port 1 single-byte write over zero, then read back
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 64'h20, 64'hFFFFFFFFFFFFFFAB, 8'h01);
    exp1.push_back(64'd0);
    @(negedge clk);
    checkOutput("wr1_req1_ready", 64'(req1_ready), 64'd1);
    checkOutput("wr1_mem_waddr", mem_waddr, 64'h20);
    checkOutput("wr1_mem_wstrb", 64'(mem_wstrb), 64'h01);
    next_cycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 64'h20, 0, 0);
    exp1.push_back(PAT_B);
    @(negedge clk);
    checkOutput("rd1_req1_ready", 64'(req1_ready), 64'd1);
    checkOutput("rd1_mem_raddr", mem_raddr, 64'h20);
    next_cycle();

    // Idle cycle: memory side quiet
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("idle_req0_ready", 64'(req0_ready), 64'd0);
    checkOutput("idle_req1_ready", 64'(req1_ready), 64'd0);
    checkOutput("idle_mem_wvalid", 64'(mem_wvalid), 64'd0);
    checkOutput("idle_mem_raddr", mem_raddr, 64'd0);
    next_cycle();

    // Both ports reading continuously: grants 0,1,0,1,0
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 64'h10, 0, 0, 1, 0, 64'h20, 0, 0);
      if (i % 2 == 0) exp0.push_back(PAT_A);
      else            exp1.push_back(PAT_B);
      @(negedge clk);
      checkOutput($sformatf("rr%0d_req0_ready", i), 64'(req0_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
      checkOutput($sformatf("rr%0d_req1_ready", i), 64'(req1_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
      next_cycle();
    end

    // Port 1 fills its slot and stalls; port 0 streams alone
    rsp1_ready = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 64'h20, 0, 0);
    exp1.push_back(PAT_B);
    @(negedge clk);
    checkOutput("fill1_req1_ready", 64'(req1_ready), 64'd1);
    next_cycle();
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1, 0, 64'h10, 0, 0, 1, 0, 64'h20, 0, 0);
      exp0.push_back(PAT_A);
      @(negedge clk);
      checkOutput($sformatf("stall%0d_req0_ready", j), 64'(req0_ready), 64'd1);
      checkOutput($sformatf("stall%0d_req1_ready", j), 64'(req1_ready), 64'd0);
      checkOutput($sformatf("stall%0d_rsp1_valid", j), 64'(rsp1_valid), 64'd1);
      next_cycle();
    end
    rsp1_ready = 1'b1;
    applyStimulus(1, 0, 64'h10, 0, 0, 1, 0, 64'h20, 0, 0);
    exp1.push_back(PAT_B);
    @(negedge clk);
    checkOutput("unstall_req1_ready", 64'(req1_ready), 64'd1);
    checkOutput("unstall_req0_ready", 64'(req0_ready), 64'd0);
    next_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // Reset while a response is held and a write is pending
    rsp0_ready = 1'b0;
    applyStimulus(1, 0, 64'h10, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("prerst_req0_ready", 64'(req0_ready), 64'd1);
    next_cycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 64'h40, 64'hDEADBEEF00005555, 8'hFF);
    #1;
    checkOutput("prerst_rsp0_valid", 64'(rsp0_valid), 64'd1);
    checkOutput("prerst_rsp0_rdata", rsp0_rdata, PAT_A);
    checkOutput("prerst_mem_wvalid", 64'(mem_wvalid), 64'd1);
    #1;
    rst = 1'b1;
    exp0.delete();
    exp1.delete();
    #1;
    checkOutput("rst_async_rsp0_valid", 64'(rsp0_valid), 64'd0);
    checkOutput("rst_async_rsp0_rdata", rsp0_rdata, 64'd0);
    checkOutput("rst_async_mem_wvalid", 64'(mem_wvalid), 64'd0);
    checkOutput("rst_async_req1_ready", 64'(req1_ready), 64'd0);
    next_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rsp0_ready = 1'b1;
    rst = 1'b0;

    // After reset the pointer favours port 0; memory kept its contents
    applyStimulus(1, 0, 64'h10, 0, 0, 1, 0, 64'h40, 0, 0);
    exp0.push_back(PAT_A);
    @(negedge clk);
    checkOutput("postrst_req0_ready", 64'(req0_ready), 64'd1);
    checkOutput("postrst_req1_ready", 64'(req1_ready), 64'd0);
    next_cycle();
    exp1.push_back(64'd0);
    @(negedge clk);
    checkOutput("postrst2_req1_ready", 64'(req1_ready), 64'd1);
    next_cycle();

    // Extra single-port traffic: 5 grants on port 0 and 3 on port 1 since reset
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 64'h10, 0, 0, 0, 0, 0, 0, 0);
      exp0.push_back(PAT_A);
      @(negedge clk);
      checkOutput($sformatf("b2b0_%0d_req0_ready", k), 64'(req0_ready), 64'd1);
      next_cycle();
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 64'h20, 0, 0);
      exp1.push_back(PAT_B);
      @(negedge clk);
      checkOutput($sformatf("b2b1_%0d_req1_ready", k), 64'(req1_ready), 64'd1);
      next_cycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) next_cycle();

    checkOutput("exp0_drained", 64'(exp0.size()), 64'd0);
    checkOutput("exp1_drained", 64'(exp1.size()), 64'd0);
`ifdef PYC_MEM_ARB_STATS_EN
    checkOutput("stat_grant0", 64'(stat_grant0), 64'd5);
    checkOutput("stat_grant1", 64'(stat_grant1), 64'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pyc_mem_arb.md
PYC_MEM_ARB -- requirements
Module: pyc_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64: byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: access width; STRB_WIDTH = (DATA_WIDTH+7)/8.
REQ-003 SHALL have ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have, for each requester N in {0,1}:
- reqN_valid  in  1  request present.
- reqN_ready  out  1  request accepted this cycle.
- reqN_write  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_WIDTH  byte address.
- reqN_wdata  in  DATA_WIDTH  write data.
- reqN_wstrb  in  STRB_WIDTH  byte enables.
- rspN_valid  out  1  response held.
- rspN_ready  in  1  response consumed.
- rspN_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-005 SHALL have memory-side ports matching the byte memory:
- mem_raddr  out  ADDR_WIDTH  read address.
- mem_rdata  in  DATA_WIDTH  combinational read data.
- mem_wvalid  out  1  write strobe.
- mem_waddr  out  ADDR_WIDTH  write address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_wstrb  out  STRB_WIDTH  byte enables.

Function
REQ-006 Port N SHALL be eligible when reqN_valid=1 and its response slot is empty or drains this cycle (rspN_valid & rspN_ready).
REQ-007 At most one grant per cycle; reqN_ready=1 only for the granted port, and only combinationally from the current eligibility.
REQ-008 Only one port eligible -> grant it; both eligible -> grant the port not granted last (round-robin pointer, reset value: port 0 wins).
REQ-009 Pointer SHALL update only on a cycle where both ports are eligible.
REQ-010 Granted read: mem_raddr = granted addr in the grant cycle; mem_rdata is captured into the port's response slot at that clock edge.
REQ-011 Granted write: mem_wvalid=1, mem_waddr/mem_wdata/mem_wstrb driven from the granted port in the grant cycle; slot loaded with rdata=0.
REQ-012 No grant: mem_wvalid=0; mem_raddr/mem_waddr/mem_wdata/mem_wstrb = 0.
REQ-013 Latency: rspN_valid rises exactly 1 cycle after grant; slot holds rspN_rdata stable until rspN_ready.
REQ-014 Simultaneous drain and new grant on the same port SHALL load the new response (back-to-back, one access per cycle sustained).
REQ-015 Read after write to the same address on consecutive grants SHALL return the written bytes.
REQ-016 Full slot with no drain: port not eligible, reqN_ready=0, request held by requester.

Reset
REQ-017 rst asserted SHALL immediately clear rsp0_valid, rsp1_valid, rspN_rdata to 0, pointer to port 0; mem_wvalid deasserts combinationally.
REQ-018 Reset mid-transaction SHALL drop buffered responses; memory contents are untouched.

Configuration
REQ-019 Macro PYC_MEM_ARB_STATS_EN defined: outputs stat_grant0, stat_grant1 (32 bits each) count grants per port, saturate at 0xFFFFFFFF, reset to 0.
REQ-020 Macro undefined: stat ports and counters absent; all other behaviour identical.

Structure
REQ-021 Package pyc_mem_arb_pkg SHALL hold port-index typedef (1 bit), NUM_PORTS=2, STAT_WIDTH=32.
REQ-022 Sub-module pyc_mem_arb_rsp_slot SHALL implement the one-entry response buffer, instantiated once per port.

Verification
REQ-023 Port 0 writes 0x1122334455667788 strb 0xFF addr 0x10, then reads 0x10 -> rsp0_rdata=0x1122334455667788 one cycle after read grant.
REQ-024 Both ports request reads continuously, rsp ready=1 -> grants alternate 0,1,0,1; each port sees one response per 2 cycles.
REQ-025 rsp1_ready=0 with rsp1 slot full -> req1_ready=0, port 0 granted every cycle; raise rsp1_ready -> port 1 granted same cycle.
REQ-026 Write strb 0x01 data 0xAB at addr 0x20 over 0x0 -> read 0x20 returns 0x00000000000000AB.
REQ-027 Assert rst while rsp0_valid=1 -> rsp0_valid=0 without clock edge; after release first dual request grants port 0.
REQ-028 With PYC_MEM_ARB_STATS_EN, 5 grants port 0 and 3 port 1 -> stat_grant0=5, stat_grant1=3.
